// File: rtl/adder_share_arb_if.sv
// Requester-side bus of the shared-adder arbiter: operands and handshake in,
// grant, per-requester ack and registered result out.
interface adder_share_arb_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       cin_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      sum_out;
  logic                  cout_out;
  logic                  busy;

  modport master (
    output req, lock, a_in, b_in, cin_in,
    input  gnt, ack, sum_out, cout_out, busy
  );

  modport slave (
    input  req, lock, a_in, b_in, cin_in,
    output gnt, ack, sum_out, cout_out, busy
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter feeding one shared ripple adder through a two-stage pipeline.
// Optional multi-word carry chaining with grant hold: define ADDER_ARB_LOCK_EN.
module adder_share_ripple #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] c;

  assign c[0] = cin_i;
  for (genvar k = 0; k < WIDTH; k++) begin : g_fa
    assign sum_o[k] = a_i[k] ^ b_i[k] ^ c[k];
    assign c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
  end
  assign cout_o = c[WIDTH];
endmodule

module adder_share_arb #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic               clk,
  input  logic               rst,
  adder_share_arb_if.slave   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d, win, win_next;
  logic [NREQ-1:0]  gnt_c, ack_q, ack_d;
  logic             xfer;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             cin_sel;

  logic             op_valid_q, op_cin_q;
  logic [PW-1:0]    op_tag_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] sum_q, add_sum;
  logic             cout_q, add_cout;

`ifdef ADDER_ARB_LOCK_EN
  logic             lock_q;
  logic [PW-1:0]    lock_owner_q;
  logic             chain_cout_q;
`endif

  // Scan downward so the last hit is the first set bit at or above ptr.
  always_comb begin : arb
    int idx;
    idx   = 0;
    gnt_c = '0;
    win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[idx]) begin
        gnt_c      = '0;
        gnt_c[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
`ifdef ADDER_ARB_LOCK_EN
    if (lock_q) begin
      gnt_c = '0;
      win   = lock_owner_q;
      if (bus.req[lock_owner_q]) gnt_c[lock_owner_q] = 1'b1;
    end
`endif
    if (rst) gnt_c = '0;
  end

  assign xfer     = |gnt_c;
  assign win_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  assign a_sel    = bus.a_in[int'(win)*WIDTH +: WIDTH];
  assign b_sel    = bus.b_in[int'(win)*WIDTH +: WIDTH];

  always_comb begin
    cin_sel = bus.cin_in[win];
    ptr_d   = ptr_q;
    if (xfer) ptr_d = win_next;
`ifdef ADDER_ARB_LOCK_EN
    // Chained words take the owner's previous carry, live from stage 1 when it is there.
    if (lock_q) begin
      cin_sel = (op_valid_q && op_tag_q == lock_owner_q) ? add_cout : chain_cout_q;
      if (bus.lock[win]) ptr_d = ptr_q;
    end
`endif
  end

  always_comb begin
    ack_d = '0;
    if (op_valid_q) ack_d[op_tag_q] = 1'b1;
  end

  adder_share_ripple #(.WIDTH(WIDTH)) u_adder (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .cin_i (op_cin_q),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      op_valid_q   <= 1'b0;
      op_tag_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      ack_q        <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
`ifdef ADDER_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
      chain_cout_q <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      op_valid_q <= xfer;
      ack_q      <= ack_d;
      if (xfer) begin
        op_a_q   <= a_sel;
        op_b_q   <= b_sel;
        op_cin_q <= cin_sel;
        op_tag_q <= win;
      end
      if (op_valid_q) begin
        sum_q  <= add_sum;
        cout_q <= add_cout;
      end
`ifdef ADDER_ARB_LOCK_EN
      if (xfer) begin
        lock_q       <= bus.lock[win];
        lock_owner_q <= win;
      end
      if (op_valid_q && op_tag_q == lock_owner_q) chain_cout_q <= add_cout;
`endif
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.ack      = ack_q;
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
`ifdef ADDER_ARB_LOCK_EN
  assign bus.busy     = op_valid_q | lock_q;
`else
  assign bus.busy     = op_valid_q;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// Randomized and directed bench for adder_share_arb against a cycle-level
// behavioural model (grant scan, queue-free two-stage result timing, carry chaining).
module tb_adder_share_arb;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

  adder_share_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int           m_ptr;
  bit           m_s1v;
  int           m_s1tag;
  logic [W-1:0] m_s1sum;
  bit           m_s1cout;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_sum;
  bit           m_cout;
  bit           m_lockq;
  int           m_owner;
  bit           last_cout [N];
  logic [N-1:0] eg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_s1v = 0; m_s1tag = 0; m_s1sum = '0; m_s1cout = 0;
    m_ack = '0; m_sum = '0; m_cout = 0; m_lockq = 0; m_owner = 0;
    for (int i = 0; i < N; i++) last_cout[i] = 0;
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (rst) return g;
    if (m_lockq) begin
      if (bus.req[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      if (bus.req[(m_ptr + k) % N]) begin
        g[(m_ptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
  task automatic step();
    int         w;
    bit         cu;
    logic [W:0] full;
    @(negedge clk);
    eg = exp_gnt();
    chk("gnt",  32'(bus.gnt),      32'(eg));
    chk("ack",  32'(bus.ack),      32'(m_ack));
    chk("sum",  32'(bus.sum_out),  32'(m_sum));
    chk("cout", 32'(bus.cout_out), 32'(m_cout));
    chk("busy", 32'(bus.busy),     32'(m_s1v | m_lockq));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ack = '0;
      if (m_s1v) begin
        m_ack[m_s1tag] = 1'b1;
        m_sum  = m_s1sum;
        m_cout = m_s1cout;
      end
      m_s1v = 0;
      w = -1;
      for (int k = 0; k < N; k++) if (eg[k]) w = k;
      if (w >= 0) begin
        cu = bus.cin_in[w];
`ifdef ADDER_ARB_LOCK_EN
        if (m_lockq) cu = last_cout[w];
`endif
        full = {1'b0, bus.a_in[w*W +: W]} + {1'b0, bus.b_in[w*W +: W]} + (W+1)'(cu);
        m_s1v = 1; m_s1tag = w; m_s1sum = full[W-1:0]; m_s1cout = full[W];
        last_cout[w] = full[W];
`ifdef ADDER_ARB_LOCK_EN
        if (!m_lockq || !bus.lock[w]) m_ptr = (w + 1) % N;
        m_lockq = bus.lock[w];
        m_owner = w;
`else
        m_ptr = (w + 1) % N;
`endif
      end
    end
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 7))
        0:       bus.a_in[i*W +: W] = '1;
        1:       bus.a_in[i*W +: W] = '0;
        default: bus.a_in[i*W +: W] = W'($urandom);
      endcase
      bus.b_in[i*W +: W] = ($urandom_range(0, 5) == 0) ? W'(1) : W'($urandom);
      bus.cin_in[i] = 1'($urandom);
    end
  endtask

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.a_in[r*W +: W] = a;
    bus.b_in[r*W +: W] = b;
    bus.cin_in[r]      = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.lock = '0; bus.a_in = '0; bus.b_in = '0; bus.cin_in = '0;
    model_reset();
    step(); step();
    chk("rst_ack",  32'(bus.ack),     32'h0);
    chk("rst_sum",  32'(bus.sum_out), 32'h0);
    chk("rst_busy", 32'(bus.busy),    32'h0);
    rst = 1'b0;

    // Single request
    bus.req = 4'b0001; set_ops(0, 16'h1234, 16'h0FF0, 1'b1); #1;
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    step();
    bus.req = '0;
    step();
    chk("single_ack",  32'(bus.ack),      32'h1);
    chk("single_sum",  32'(bus.sum_out),  32'h2225);
    chk("single_cout", 32'(bus.cout_out), 32'h0);

    // Overflow on requester 3
    bus.req = 4'b1000; set_ops(3, 16'hFFFF, 16'h0001, 1'b0); #1;
    chk("ovf_gnt", 32'(bus.gnt), 32'h8);
    step();
    bus.req = '0;
    step();
    chk("ovf_ack",  32'(bus.ack),      32'h8);
    chk("ovf_sum",  32'(bus.sum_out),  32'h0);
    chk("ovf_cout", 32'(bus.cout_out), 32'h1);

    // Reset one cycle after a transfer discards it
    bus.req = 4'b0010; rand_ops(); #1;
    step();
    bus.req = 4'b1111; rst = 1'b1; model_reset(); #1;
    chk("midrst_gnt",  32'(bus.gnt),      32'h0);
    chk("midrst_ack",  32'(bus.ack),      32'h0);
    chk("midrst_sum",  32'(bus.sum_out),  32'h0);
    chk("midrst_cout", 32'(bus.cout_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy),     32'h0);
    step(); step();
    rst = 1'b0; bus.req = '0;
    step();
    chk("midrst_noack1", 32'(bus.ack), 32'h0);
    step();
    chk("midrst_noack2", 32'(bus.ack), 32'h0);
    bus.req = 4'b0110; #1;
    chk("postrst_gnt", 32'(bus.gnt), 32'h2);

    // Round-robin with all requesting, ptr at 0
    for (int j = 0; j < 10; j++) begin
      bus.req = (j < 8) ? 4'b1111 : 4'b0000;
      rand_ops(); #1;
      if (j < 8) chk("rr_gnt", 32'(bus.gnt), 32'(1 << (j % 4)));
      step();
      if (j >= 1 && j - 1 < 8) chk("rr_ack", 32'(bus.ack), 32'(1 << ((j - 1) % 4)));
    end

    // Two-word chain on requester 2 while requester 0 waits
    bus.req = 4'b0010; #1;
    step();
    bus.req = 4'b0101; bus.lock = 4'b0100;
    set_ops(2, 16'hFFFF, 16'h0001, 1'b0); set_ops(0, 16'h0101, 16'h0202, 1'b0); #1;
    chk("chain_w0_gnt", 32'(bus.gnt), 32'h4);
    step();
    bus.lock = 4'b0000; set_ops(2, 16'h0000, 16'h0000, 1'b0); #1;
`ifdef ADDER_ARB_LOCK_EN
    chk("chain_w1_gnt", 32'(bus.gnt), 32'h4);
    step();
    bus.req = 4'b0001; #1;
    chk("chain_r0_after", 32'(bus.gnt), 32'h1);
    step();
    chk("chain_w1_ack",  32'(bus.ack),      32'h4);
    chk("chain_w1_sum",  32'(bus.sum_out),  32'h0001);
    chk("chain_w1_cout", 32'(bus.cout_out), 32'h0);
`else
    chk("nolock_r0_between", 32'(bus.gnt), 32'h1);
    step();
    chk("nolock_w0_sum",  32'(bus.sum_out),  32'h0000);
    chk("nolock_w0_cout", 32'(bus.cout_out), 32'h1);
    chk("nolock_w1_gnt",  32'(bus.gnt),      32'h4);
    step();
    bus.req = '0;
    step();
    chk("nolock_w1_ack", 32'(bus.ack),     32'h4);
    chk("nolock_w1_sum", 32'(bus.sum_out), 32'h0000);
`endif
    bus.req = '0; bus.lock = '0;
    step(); step();

    // Randomized traffic with occasional resets
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 69) == 0) begin
        rst = 1'b1; model_reset();
      end else begin
        rst = 1'b0;
      end
      bus.req = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
`ifdef ADDER_ARB_LOCK_EN
      bus.lock = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
`else
      bus.lock = N'($urandom);
`endif
      rand_ops();
      step();
    end
    rst = 1'b0; bus.req = '0; bus.lock = '0;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
